// File: rtl/md_unit_iter.sv
// ---------------------------------------------------------------------------
// md_unit_iter
//
// Iterative multiply/divide unit that owns the HI/LO register pair. It sits
// beside the ALU in EX. Multiplies use a radix-2 shift-add datapath. Divides
// use a restoring divider. Both retire one bit per cycle, so an arithmetic op
// keeps busy high for WIDTH+1 cycles (WIDTH iterations plus one fix-up cycle).
//
// Optional feature macro: MDU_MADD_EN
//   defined   : ops 7-10 (MADD/MADDU/MSUB/MSUBU) accumulate into {HI,LO}
//   undefined : ops 7-10 decode as NOP and no accumulate adder is built
//
// Parameters:
//   WIDTH  operand width and width of each of HI and LO
//   CNT_W  iteration counter width, must satisfy 2**CNT_W > WIDTH
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset
//   flush    blocks acceptance of op this cycle (never cancels an op in flight)
//   op       0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//            7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP
//   src_a    rs operand (dividend, multiplicand, MTHI/MTLO data)
//   src_b    rt operand (divisor, multiplier)
//   rd_hi    read select, 1 = HI, 0 = LO
//   busy     registered, high while an arithmetic op is in flight
//   rd_data  combinational HI/LO read port
// ---------------------------------------------------------------------------
module md_unit_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     counter;
  logic                 is_div_r;
  logic                 neg_a_r;
  logic                 neg_b_r;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   wk;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;
`ifdef MDU_MADD_EN
  logic                 acc_r;
  logic                 sub_r;
`endif

  // Op decode
  logic                 op_is_mul;
  logic                 op_is_div;
  logic                 op_signed;
`ifdef MDU_MADD_EN
  logic                 op_is_acc;
  logic                 op_is_sub;
`endif
  logic                 start;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  // Iteration datapath
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_next;

  // Fix-up datapath
  logic                 prod_neg;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed;
  logic [WIDTH-1:0]     rem_fixed;
  logic                 fix_write;
  logic [2*WIDTH-1:0]   fix_hilo;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0]   acc_sum;
  logic [2*WIDTH-1:0]   acc_diff;
`endif

  assign rd_data = rd_hi ? hi : lo;

  // Classify the incoming op. Only arithmetic ops start the FSM; MTHI/MTLO
  // are handled directly in IDLE.
  always_comb begin
    op_is_mul = 1'b0;
    op_is_div = 1'b0;
    op_signed = 1'b0;
`ifdef MDU_MADD_EN
    op_is_acc = 1'b0;
    op_is_sub = 1'b0;
`endif
    case (op)
      OP_MULT:  begin op_is_mul = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_is_mul = 1'b1; end
      OP_DIV:   begin op_is_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  begin op_is_div = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin op_is_mul = 1'b1; op_signed = 1'b1; op_is_acc = 1'b1; end
      OP_MADDU: begin op_is_mul = 1'b1; op_is_acc = 1'b1; end
      OP_MSUB:  begin op_is_mul = 1'b1; op_signed = 1'b1; op_is_acc = 1'b1; op_is_sub = 1'b1; end
      OP_MSUBU: begin op_is_mul = 1'b1; op_is_acc = 1'b1; op_is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign start = (state == IDLE) && !flush && (op_is_mul || op_is_div);

  // The core works on magnitudes; signs are reapplied in FIX. The magnitude
  // of INT_MIN is 2**(WIDTH-1), which is still representable unsigned.
  assign abs_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Shift-add multiply: wk holds {partial product, remaining multiplier
  // bits}. Each step conditionally adds the multiplicand to the upper half
  // and shifts the whole register right, carry included.
  always_comb begin
    mul_sum  = {1'b0, wk[2*WIDTH-1:WIDTH]} + (wk[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, wk[WIDTH-1:1]};
  end

  // Restoring divide: wk holds {partial remainder, dividend/quotient}. The
  // next dividend bit is shifted into the remainder; if the divisor fits it
  // is subtracted and a 1 is shifted into the quotient end.
  always_comb begin
    div_shift = {wk[2*WIDTH-1:WIDTH], wk[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[WIDTH-1:0] - opnd;
    div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), wk[WIDTH-2:0], div_ge};
  end

  // Sign fix-up. Quotient is negative when the operand signs differ, the
  // remainder follows the dividend, so truncation is toward zero.
  always_comb begin
    prod_neg   = neg_a_r ^ neg_b_r;
    prod_fixed = prod_neg ? -wk : wk;
    quo_fixed  = prod_neg ? -wk[WIDTH-1:0] : wk[WIDTH-1:0];
    rem_fixed  = neg_a_r ? -wk[2*WIDTH-1:WIDTH] : wk[2*WIDTH-1:WIDTH];
  end

`ifdef MDU_MADD_EN
  assign acc_sum  = {hi, lo} + prod_fixed;
  assign acc_diff = {hi, lo} - prod_fixed;
`endif

  // Select what FIX writes to {HI,LO}. A zero divisor still runs the full
  // latency but leaves HI/LO untouched.
  always_comb begin
    fix_write = !(is_div_r && (opnd == '0));
    fix_hilo  = prod_fixed;
    if (is_div_r) begin
      fix_hilo = {rem_fixed, quo_fixed};
    end
`ifdef MDU_MADD_EN
    else if (acc_r) begin
      fix_hilo = sub_r ? acc_diff : acc_sum;
    end
`endif
  end

  // Control FSM, work registers and the HI/LO pair. busy is registered and
  // tracks exactly the CALC and FIX cycles. Reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      counter  <= '0;
      is_div_r <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      opnd     <= '0;
      wk       <= '0;
      hi       <= '0;
      lo       <= '0;
`ifdef MDU_MADD_EN
      acc_r    <= 1'b0;
      sub_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            counter  <= '0;
            is_div_r <= op_is_div;
            neg_a_r  <= op_signed & src_a[WIDTH-1];
            neg_b_r  <= op_signed & src_b[WIDTH-1];
`ifdef MDU_MADD_EN
            acc_r    <= op_is_acc;
            sub_r    <= op_is_sub;
`endif
            if (op_is_div) begin
              opnd <= abs_b;
              wk   <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd <= abs_a;
              wk   <= {{WIDTH{1'b0}}, abs_b};
            end
          end else if (!flush && (op == OP_MTHI)) begin
            hi <= src_a;
          end else if (!flush && (op == OP_MTLO)) begin
            lo <= src_a;
          end
        end
        CALC: begin
          wk      <= is_div_r ? div_next : mul_next;
          counter <= counter + 1'b1;
          if (counter == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (fix_write) begin
            hi <= fix_hilo[2*WIDTH-1:WIDTH];
            lo <= fix_hilo[WIDTH-1:0];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_iter.sv
// ---------------------------------------------------------------------------
// tb_md_unit_iter
//
// Self-checking bench for md_unit_iter (WIDTH=32). Expected HI/LO values come
// from a plain-arithmetic reference model using 64-bit integer multiply,
// divide and modulo. Directed cases first, then a randomized op sequence,
// then a reset-abort case. Honours MDU_MADD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_md_unit_iter;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADD  = 4'd7;
  localparam logic [3:0] MADDU = 4'd8;
  localparam logic [3:0] MSUB  = 4'd9;
  localparam logic [3:0] MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] rd_data;

  int          n_compared = 0;
  int          n_mismatch = 0;
  logic [63:0] model_hilo;

  always #5 clk = ~clk;

  md_unit_iter #(
    .WIDTH(WIDTH),
    .CNT_W(6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .rd_hi  (rd_hi),
    .busy   (busy),
    .rd_data(rd_data)
  );

  function automatic bit isArith(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= MULT && o <= DIVU) || (o >= MADD && o <= MSUBU);
`else
    return (o >= MULT && o <= DIVU);
`endif
  endfunction

  // Reference model: new {HI,LO} from op, operands and old {HI,LO}.
  function automatic logic [63:0] modelResult(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] old);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, sp, up, q64, r64;
    logic [31:0] uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    sp = sa * sb;
    up = ua * ub;
    case (o)
      MULT:  return sp;
      MULTU: return up;
      DIV: begin
        if (b == 32'd0) return old;
        sq = sa / sb;
        sr = sa % sb;
        q64 = sq;
        r64 = sr;
        return {r64[31:0], q64[31:0]};
      end
      DIVU: begin
        if (b == 32'd0) return old;
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      MTHI:  return {a, old[31:0]};
      MTLO:  return {old[63:32], a};
`ifdef MDU_MADD_EN
      MADD:  return old + sp;
      MADDU: return old + up;
      MSUB:  return old - sp;
      MSUBU: return old - up;
`endif
      default: return old;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatch++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reads HI then LO mid-cycle; takes 2 time units, well before the next edge.
  task automatic readHiLo(output logic [63:0] v);
    rd_hi = 1'b1;
    #1;
    v[63:32] = rd_data;
    rd_hi = 1'b0;
    #1;
    v[31:0] = rd_data;
  endtask

  // Drives an op for one clock edge, then returns to NOP. Called while clk is
  // low; returns at the following negedge.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    op    = o;
    src_a = a;
    src_b = b;
    flush = fl;
    @(negedge clk);
    op    = 4'd0;
    flush = 1'b0;
  endtask

  // Issues one op, measures busy length, checks old HI/LO is visible while
  // busy and the final HI/LO against the model.
  task automatic runOp(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    logic [63:0] obs, exp, old;
    int          cycles;
    old = model_hilo;
    exp = fl ? old : modelResult(o, a, b, old);
    applyStimulus(o, a, b, fl);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (cycles == 5) begin
        readHiLo(obs);
        checkOutput({tag, " hilo while busy"}, obs, old);
      end
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, 64'(cycles), (isArith(o) && !fl) ? 64'(LAT) : 64'd0);
    readHiLo(obs);
    checkOutput({tag, " hilo"}, obs, exp);
    model_hilo = exp;
  endtask

  initial begin
    logic [63:0] obs, exp;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rfl;
    int          cycles;

    reset = 1'b1;
    flush = 1'b0;
    op    = 4'd0;
    src_a = '0;
    src_b = '0;
    rd_hi = 1'b0;
    model_hilo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset busy", 64'(busy), 64'd0);
    readHiLo(obs);
    checkOutput("reset hilo", obs, 64'd0);

    $display("[TB] directed multiply/divide");
    runOp("mult neg", MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    runOp("multu", MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    runOp("div -7/2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    runOp("divu 7/2", DIVU, 32'h0000_0007, 32'h0000_0002, 1'b0);
    runOp("div intmin/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runOp("div 7/-2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

    $display("[TB] move and divide by zero");
    runOp("mthi", MTHI, 32'h0000_1234, 32'h0, 1'b0);
    runOp("divu by zero", DIVU, 32'h0000_0005, 32'h0, 1'b0);
    runOp("div by zero", DIV, 32'hFFFF_FF00, 32'h0, 1'b0);
    runOp("mtlo flushed", MTLO, 32'h0000_0055, 32'h0, 1'b1);
    runOp("mult flushed", MULT, 32'h0000_0003, 32'h0000_0003, 1'b1);

    $display("[TB] op issued while busy is ignored");
    exp = modelResult(MULT, 32'h0000_1000, 32'hFFFF_FFFD, model_hilo);
    applyStimulus(MULT, 32'h0000_1000, 32'hFFFF_FFFD, 1'b0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (cycles == 3) begin
        op    = MULT;
        src_a = 32'h7777_7777;
        src_b = 32'h0000_0009;
      end else if (cycles == 4) begin
        op    = MTLO;
        src_a = 32'hDEAD_BEEF;
      end else begin
        op = 4'd0;
      end
      @(negedge clk);
    end
    op = 4'd0;
    checkOutput("busy ignore cycles", 64'(cycles), 64'(LAT));
    readHiLo(obs);
    checkOutput("busy ignore hilo", obs, exp);
    model_hilo = exp;
    @(negedge clk);
    checkOutput("busy ignore no restart", 64'(busy), 64'd0);

    $display("[TB] accumulate ops");
    runOp("mthi 0", MTHI, 32'h0, 32'h0, 1'b0);
    runOp("mtlo ones", MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
    runOp("maddu 1*1", MADDU, 32'h1, 32'h1, 1'b0);
    runOp("madd neg", MADD, 32'hFFFF_FFF0, 32'h0000_0100, 1'b0);
    runOp("msub neg", MSUB, 32'h8000_0000, 32'h8000_0000, 1'b0);
    runOp("msubu", MSUBU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] randomized sequence");
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) rop = 4'($urandom_range(1, 10));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      rfl = ($urandom_range(0, 7) == 0);
      runOp($sformatf("rand %0d op %0d", i, rop), rop, ra, rb, rfl);
    end

    $display("[TB] reset during calculation");
    applyStimulus(MULTU, 32'hABCD_1234, 32'h0000_00FF, 1'b0);
    repeat (9) @(negedge clk);
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hilo = '0;
    checkOutput("abort busy", 64'(busy), 64'd0);
    readHiLo(obs);
    checkOutput("abort hilo", obs, 64'd0);
    @(negedge clk);
    checkOutput("abort stays idle", 64'(busy), 64'd0);
    runOp("after reset divu", DIVU, 32'd100, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/md_unit_iter.md
Name: md_unit_iter

Overview:
Parametrised iterative multiply/divide unit owning the HI/LO register pair. Sits beside the ALU in EX and replaces single-cycle operators with a radix-2 shift-add multiplier and a restoring divider, so latency is data-width driven. Adds multiply-accumulate/subtract modes. The pipeline stalls any HI/LO-touching instruction while busy is high.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  exception/flush of the issuing stage; blocks acceptance of op this cycle
op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, others NOP
src_a  input  WIDTH  rs operand (dividend, multiplicand, MTHI/MTLO data)
src_b  input  WIDTH  rt operand (divisor, multiplier)
rd_hi  input  1  read select: 1 = HI, 0 = LO
busy  output  1  registered; high while an arithmetic op is in flight
rd_data  output  WIDTH  combinational: HI if rd_hi else LO

Behaviour:
- Reset: HI=0, LO=0, busy=0, FSM=IDLE, counter and work registers 0. Reset mid-operation aborts it with no HI/LO write.
- FSM states: IDLE, CALC, FIX.
- IDLE, flush=0, arithmetic op (1-4, 7-10): latch operands, sign flags and op into work regs; counter=0; go to CALC; busy=1 from next cycle.
- IDLE, flush=0, MTHI/MTLO: write src_a to HI/LO at this edge; stay in IDLE.
- flush=1, or busy=1: op ignored entirely (including MTHI/MTLO). An in-flight op is never cancelled by flush.
- CALC: one iteration per cycle on magnitudes (|a|, |b| for signed ops). Multiply: 2*WIDTH-bit shift-add. Divide: restoring, one quotient bit per cycle. Counter increments; leave for FIX after WIDTH iterations (counter==WIDTH-1).
- FIX (1 cycle): apply signs; for MADD/MSUB add/subtract the 2*WIDTH product to/from {HI,LO}, modulo 2^(2*WIDTH); write HI/LO; go to IDLE; busy=0 next cycle.
- Latency: op accepted at edge T, so busy is high for cycles T+1..T+WIDTH+1. New HI/LO are visible on rd_data from cycle T+WIDTH+2; a new op is accepted in that same cycle.
- Signed divide: quotient truncates toward zero (LO); remainder takes the sign of the dividend (HI). INT_MIN / -1 gives LO=INT_MIN, HI=0.
- Divide by zero: full latency; HI and LO unchanged.
- Products: signed is a two's-complement 2*WIDTH result; unsigned is a zero-extended product.
- rd_data is always live and returns old HI/LO while busy. The pipeline must not read while busy.

Optional Feature:
MDU_MADD_EN: defined means ops 7-10 behave as above. Undefined means ops 7-10 decode as NOP (not accepted, busy stays 0) and no accumulate adder is built; FIX only applies signs.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 -> busy high 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x1234, then DIVU 5/0 -> after 33 busy cycles HI=0x1234 and LO unchanged.
- MTLO 0x55 with flush=1 -> LO unchanged; MULT issued while busy -> ignored, first result intact.
- MDU_MADD_EN set, HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0. Reset asserted at CALC cycle 10 -> busy=0, HI=LO=0.
